spi_slave_param: RTL
====================

// Module: spi_slave_param
// PURPOSE
//  Parametrised second-generation SPI slave front end for the SPI/RAM subsystem. Frames one
//  command of CMD_W opcode bits plus DATA_W payload bits per SS_n assertion and presents it to
//  the memory side as a one-cycle rx_valid pulse. For the read-data opcode it waits for
//  tx_valid, accepts one word with tx_ready and shifts it out on MISO. Mid-frame SS_n aborts,
//  tx-wait timeouts and frame errors are detected and flagged.
// PARAMETERS
//  DATA_W       8    payload bits per frame, also the MISO read-back width (>=2)
//  CMD_W        2    opcode bits at the head of each frame (>=2; top 2 bits select the operation)
//  TX_WAIT_MAX  16   max cycles in TX_WAIT before timeout (>=1)
//  FRAME_W      CMD_W+DATA_W (localparam, not overridable)
// PORTS
//  clk        in   1        clock, shared with the SPI bit clock; all logic on posedge
//  rst_n      in   1        synchronous, active-low reset
//  SS_n       in   1        slave select, active low
//  MOSI       in   1        serial data in, MSB first
//  MISO       out  1        serial data out, MSB first
//  rx_data    out  FRAME_W  {opcode, payload} of the last complete frame
//  rx_valid   out  1        one-cycle pulse: rx_data is new
//  tx_data    in   DATA_W   read-back word from the memory side
//  tx_valid   in   1        tx_data valid
//  tx_ready   out  1        one-cycle pulse: tx_data accepted this cycle
//  busy       out  1        high in any state other than IDLE
//  frame_err  out  1        one-cycle pulse on an abort or a timeout
// BEHAVIOUR
//  Reset (rst_n=0 sampled at posedge): state=IDLE; MISO, rx_data, rx_valid, tx_ready, busy and
//   frame_err are all 0; the shift register and both counters are cleared. Reset overrides
//   every other event.
//  States (encoding in package): IDLE, RX, TX_WAIT, TX, DONE.
//  IDLE: if SS_n=0, go to RX with bit_cnt=0. MOSI is ignored in this start cycle.
//  RX: on each cycle, shift MOSI into the LSB of sreg and increment bit_cnt.
//   - On the cycle with bit_cnt==FRAME_W-1, load rx_data={sreg[FRAME_W-2:0],MOSI} and
//     pulse rx_valid on the next cycle.
//   - Next state is TX_WAIT if the top two opcode bits are 2'b11, otherwise DONE.
//   - Opcodes 00, 01 and 10 are write-addr, write-data and read-addr; this block does not
//     distinguish them.
//  TX_WAIT: the timeout counter increments each cycle.
//   - If tx_valid=1: tx_ready=1 in that same cycle, sreg[DATA_W-1:0]<=tx_data, go to TX.
//   - Else, when wait_cnt==TX_WAIT_MAX-1: pulse frame_err and go to DONE.
//  TX: MISO is the registered sreg MSB. The first bit appears on the cycle after acceptance.
//   Exactly DATA_W bits are sent, then the block goes to DONE. MISO=0 in every state other
//   than TX.
//  DONE: hold until SS_n=1, then go to IDLE. Only one frame is taken per SS_n assertion.
//  SS_n=1 in RX, TX_WAIT or TX is an abort: go to IDLE and pulse frame_err the next cycle.
//   No rx_valid is produced for a partial frame, and rx_data keeps its old value.
//   SS_n=1 in DONE is not an error.
//  Simultaneous events:
//   - SS_n=1 together with the last RX bit: abort wins, no rx_valid.
//   - tx_valid together with timeout expiry: accept wins.
//   - tx_valid outside TX_WAIT is ignored (tx_ready=0).
//  Widths: bit_cnt uses $clog2(FRAME_W+1) bits; wait_cnt uses $clog2(TX_WAIT_MAX+1) bits.
//   Neither counter wraps; each is cleared on every state entry.
//  Latency: last MOSI bit -> rx_valid = 1 cycle. tx accept -> first MISO bit = 1 cycle.
// STRUCTURE
//  spi_pkg holds: state encoding localparams, opcode constants OP_WR_ADDR=2'b00,
//   OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11.
//  Sub-module spi_bit_counter (params WIDTH, MAX): synchronous clear, enable, terminal-count
//   output. Instantiate it twice, for bit_cnt and wait_cnt. Keep the FSM and shift register
//   in this module.
// TESTING
//  1. Reset mid-TX with rst_n=0 for 1 cycle -> all outputs 0 and state IDLE on the next cycle.
//  2. DATA_W=8, CMD_W=2, frame 10'b00_1010_0101 -> one rx_valid, rx_data=10'h0A5, MISO=0,
//     no tx_ready.
//  3. Frame 11_xxxxxxxx, tx_valid with tx_data=8'hC3 three cycles later -> tx_ready pulse,
//     then MISO shows 1,1,0,0,0,0,1,1, then DONE.
//  4. Read-data frame with no tx_valid, TX_WAIT_MAX=16 -> frame_err 16 cycles after TX_WAIT
//     entry; MISO stays 0.
//  5. SS_n rises after 5 RX bits -> frame_err pulse, no rx_valid, rx_data unchanged;
//     the next full frame is received correctly.
//  6. Regression at DATA_W=16, CMD_W=3, TX_WAIT_MAX=1 -> same behaviour as tests 2-4;
//     tx_valid arriving on the expiry cycle is accepted, not timed out.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding and opcode constants for the SPI slave front end
// Purpose: FSM state encoding and the opcode map. These are used by spi_slave_param.
// Contents: state_t enum, OP_* opcode constants, op_needs_tx() opcode decode helper.
package spi_pkg;

   localparam logic [2:0] ST_IDLE_ENC    = 3'd0;
   localparam logic [2:0] ST_RX_ENC      = 3'd1;
   localparam logic [2:0] ST_TX_WAIT_ENC = 3'd2;
   localparam logic [2:0] ST_TX_ENC      = 3'd3;
   localparam logic [2:0] ST_DONE_ENC    = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE    = ST_IDLE_ENC,
      ST_RX      = ST_RX_ENC,
      ST_TX_WAIT = ST_TX_WAIT_ENC,
      ST_TX      = ST_TX_ENC,
      ST_DONE    = ST_DONE_ENC
   } state_t;

   // Top two opcode bits of a frame
   localparam logic [1:0] OP_WR_ADDR = 2'b00;
   localparam logic [1:0] OP_WR_DATA = 2'b01;
   localparam logic [1:0] OP_RD_ADDR = 2'b10;
   localparam logic [1:0] OP_RD_DATA = 2'b11;

   // Only the read-data opcode needs a word shifted back out on MISO.
   // The three other opcodes are forwarded to the memory side unchanged.
   function automatic logic op_needs_tx(input logic [1:0] op);
      case (op)
         OP_WR_ADDR, OP_WR_DATA, OP_RD_ADDR: return 1'b0;
         OP_RD_DATA:                         return 1'b1;
         default:                            return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// rtl/spi_bit_counter.sv - up-counter with synchronous clear, enable and terminal-count flag
// Purpose: Counts the bits of a frame, or the cycles spent waiting for tx data.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   clr        : clear the count to 0; takes priority over en
//   en         : increment the count by one
//   cnt        : current count
//   tc         : high while cnt == MAX-1
// Saturation is left to the caller: the caller drops en once the count reaches MAX.
module spi_bit_counter #(
   parameter int WIDTH = 4,
   parameter int MAX   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] cnt,
   output logic             tc
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + WIDTH'(1);
      end
   end

   assign tc = (cnt == WIDTH'(MAX - 1));

endmodule

// File: rtl/spi_slave_param.sv
// rtl/spi_slave_param.sv - parametrised SPI slave framing one command per SS_n assertion
// Purpose: Shifts in one {opcode, payload} frame per SS_n assertion and presents it as a
//   one-cycle rx_valid pulse. For the read-data opcode it waits for tx_valid, accepts one word
//   and shifts that word out on MISO. It flags aborts and tx-wait timeouts on frame_err.
// Ports:
//   clk, rst_n           : clock (also the SPI bit clock) and synchronous active-low reset
//   SS_n, MOSI, MISO     : SPI select, serial in and serial out; MSB first
//   rx_data / rx_valid   : last complete frame / one-cycle pulse when it is new
//   tx_data / tx_valid   : read-back word from the memory side
//   tx_ready             : one-cycle pulse, tx_data taken this cycle
//   busy                 : high in any state other than IDLE
//   frame_err            : one-cycle pulse after an abort or a tx-wait timeout
module spi_slave_param
   import spi_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int CMD_W       = 2,
   parameter int TX_WAIT_MAX = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    SS_n,
   input  logic                    MOSI,
   output logic                    MISO,
   output logic [CMD_W+DATA_W-1:0] rx_data,
   output logic                    rx_valid,
   input  logic [DATA_W-1:0]       tx_data,
   input  logic                    tx_valid,
   output logic                    tx_ready,
   output logic                    busy,
   output logic                    frame_err
);

   localparam int FRAME_W = CMD_W + DATA_W;
   // The frame MSB is taken straight into rx_data on the last bit, so it is never stored.
   localparam int SREG_W  = FRAME_W - 1;
   localparam int BIT_W   = $clog2(FRAME_W + 1);
   localparam int WAIT_W  = $clog2(TX_WAIT_MAX + 1);

   state_t              state, state_nxt;
   logic [SREG_W-1:0]   sreg;
   logic [FRAME_W-1:0]  rx_frame;
   logic [BIT_W-1:0]    bit_cnt;
   logic [WAIT_W-1:0]   wait_cnt;
   logic                bit_tc, bit_en;
   logic                wait_tc, wait_en;
   logic                cnt_clr;
   logic                abort, timeout, accept;

   // The frame as it would look once the current MOSI bit is taken in.
   assign rx_frame = {sreg, MOSI};

   // Both counters restart whenever the FSM changes state.
   assign cnt_clr = (state_nxt != state);

   spi_bit_counter #(
      .WIDTH (BIT_W),
      .MAX   (FRAME_W)
   ) u_bit_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .en    (bit_en),
      .cnt   (bit_cnt),
      .tc    (bit_tc)
   );

   spi_bit_counter #(
      .WIDTH (WAIT_W),
      .MAX   (TX_WAIT_MAX)
   ) u_wait_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .en    (wait_en),
      .cnt   (wait_cnt),
      .tc    (wait_tc)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      abort     = 1'b0;
      timeout   = 1'b0;
      accept    = 1'b0;
      bit_en    = 1'b0;
      wait_en   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!SS_n) begin
               state_nxt = ST_RX;
            end
         end
         ST_RX: begin
            // An abort on the last bit also lands here, so no rx_valid is raised for it.
            if (SS_n) begin
               abort     = 1'b1;
               state_nxt = ST_IDLE;
            end else begin
               bit_en = (bit_cnt != BIT_W'(FRAME_W));
               if (bit_tc) begin
                  state_nxt = op_needs_tx(rx_frame[FRAME_W-1 -: 2]) ? ST_TX_WAIT : ST_DONE;
               end
            end
         end
         ST_TX_WAIT: begin
            if (SS_n) begin
               abort     = 1'b1;
               state_nxt = ST_IDLE;
            end else begin
               wait_en = (wait_cnt != WAIT_W'(TX_WAIT_MAX));
               // If the word arrives on the expiry cycle, it is accepted and no timeout occurs.
               if (tx_valid) begin
                  accept    = 1'b1;
                  state_nxt = ST_TX;
               end else if (wait_tc) begin
                  timeout   = 1'b1;
                  state_nxt = ST_DONE;
               end
            end
         end
         ST_TX: begin
            if (SS_n) begin
               abort     = 1'b1;
               state_nxt = ST_IDLE;
            end else begin
               bit_en = (bit_cnt != BIT_W'(FRAME_W));
               if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                  state_nxt = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            if (SS_n) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sreg      <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_valid  <= 1'b0;
         frame_err <= abort | timeout;
         if (state == ST_RX && !SS_n) begin
            sreg <= rx_frame[SREG_W-1:0];
            if (bit_tc) begin
               rx_data  <= rx_frame;
               rx_valid <= 1'b1;
            end
         end else if (accept) begin
            sreg[DATA_W-1:0] <= tx_data;
         end else if (state == ST_TX && !SS_n) begin
            sreg <= {sreg[SREG_W-2:0], 1'b0};
         end
      end
   end

   // MISO is driven straight from the stored bit, so the first bit appears one cycle after the accept.
   assign MISO     = (state == ST_TX) & sreg[DATA_W-1];
   assign tx_ready = accept;
   assign busy     = (state != ST_IDLE);

endmodule
